spi_slave_count_rx: RTL and testbench

- SPI slave receiver that sits directly upstream of the 4-digit FND display controller and produces its 14-bit display count.
- An external SPI master writes 16-bit frames. The block validates each frame, decodes the command, saturates the value to 0..9999 and holds it on counter_10hz until the next valid frame.
- SPI pins are asynchronous to clk. They are oversampled through synchronizers and sampled on detected edges.

---
 rtl/spi_slave_count_rx.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_count_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_count_rx.sv
// SPI mode-0 slave: validates 16-bit command frames, holds a 0..MAX_VALUE count (SPI_READBACK_EN: old count on miso).
// Latency: counter_10hz/rx_done/frame_err update 2 clk after the synchronized cs_n rise.
// Backpressure: none; frames are taken at line rate and sclk edges outside a frame are ignored.
module spi_slave_count_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_VALUE   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic [13:0] counter_10hz,
  output logic        rx_done,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  localparam logic [13:0] MAX_V = 14'(MAX_VALUE);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sclk_rise;
  logic                   cs_fall;
  logic                   cs_rise;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic        do_write;
  logic        do_clear;
  logic        do_err;
  logic [13:0] wr_val;

  // Idle levels on reset (sclk low, cs_n high) so release never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = RECV;
      RECV:    if (cs_rise) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_write = 1'b0;
    do_clear = 1'b0;
    do_err   = 1'b0;
    if (state == CHECK) begin
      if (bit_cnt != 5'd16) begin
        do_err = 1'b1;
      end else begin
        case (shift_reg[15:14])
          2'b01:   do_write = 1'b1;
          2'b10:   do_clear = 1'b1;
          default: do_err   = 1'b1;
        endcase
      end
    end
  end

  assign wr_val = (shift_reg[13:0] > MAX_V) ? MAX_V : shift_reg[13:0];

  // A shift coinciding with cs_rise still lands: the state change only affects the next clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (state == IDLE && cs_fall) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (state == RECV && sclk_rise) begin
      shift_reg <= {shift_reg[14:0], mosi_s};
      if (bit_cnt != 5'd17) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_10hz <= '0;
      rx_done      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done   <= do_write | do_clear;
      frame_err <= do_err;
      if (do_write) begin
        counter_10hz <= wr_val;
      end else if (do_clear) begin
        counter_10hz <= '0;
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic        sclk_fall;
  logic [15:0] tx;

  assign sclk_fall = ~sclk_s & sclk_d;

  // Master samples on sclk rise, so the next bit is presented after each fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx <= '0;
    end else if (cs_fall) begin
      tx <= {2'b00, counter_10hz};
    end else if (cs_rise) begin
      tx <= '0;
    end else if (state == RECV && sclk_fall) begin
      tx <= {tx[14:0], 1'b0};
    end
  end

  assign miso = tx[15] & ~cs_s;
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_count_rx.sv
// Directed plus randomized frames for spi_slave_count_rx, checked against a frame-level model.
module tb_spi_slave_count_rx;

  localparam int SYNC  = 2;
  localparam int MAXV  = 9999;
  localparam int LAT_MAX = SYNC + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_n = 1'b1;
  logic        miso;
  logic [13:0] counter_10hz;
  logic        rx_done;
  logic        frame_err;

  int checks = 0;
  int failures = 0;
  int model_val = 0;
  int rx_total = 0;
  int err_total = 0;
  int both_total = 0;
  int miso_hi_total = 0;

  spi_slave_count_rx #(
    .SYNC_STAGES(SYNC),
    .MAX_VALUE  (MAXV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .mosi        (mosi),
    .cs_n        (cs_n),
    .miso        (miso),
    .counter_10hz(counter_10hz),
    .rx_done     (rx_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done === 1'b1) rx_total++;
    if (frame_err === 1'b1) err_total++;
    if (rx_done === 1'b1 && frame_err === 1'b1) both_total++;
    if (miso !== 1'b0) miso_hi_total++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sends nbits of data MSB first at sclk = clk/8; returns bits seen on miso and pin-to-pulse latency.
  task automatic send_frame(input logic [31:0] data, input int nbits, input bit same_clk,
                            output logic [15:0] rd, output int lat);
    rd = '0;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      repeat (4) @(negedge clk);
      rd = {rd[14:0], miso};
      sclk = 1'b1;
      if (same_clk && i == 0) begin
        cs_n = 1'b1;
      end else begin
        repeat (4) @(negedge clk);
        sclk = 1'b0;
      end
    end
    if (!(same_clk && nbits > 0)) begin
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
    end
    lat = 0;
    while (!(rx_done === 1'b1 || frame_err === 1'b1) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] data, input int nbits, input bit same_clk);
    logic [15:0] rd;
    logic [15:0] exp_rd;
    int lat;
    int rx0;
    int er0;
    int word;
    int cmd;
    int val;
    bit ok;
    exp_rd = 16'(model_val);
    rx0 = rx_total;
    er0 = err_total;
    send_frame(data, nbits, same_clk, rd, lat);
    ok = 1'b0;
    if (nbits == 16) begin
      word = int'(data % 65536);
      cmd  = word / 16384;
      val  = word % 16384;
      if (cmd == 1) begin
        model_val = (val > MAXV) ? MAXV : val;
        ok = 1'b1;
      end else if (cmd == 2) begin
        model_val = 0;
        ok = 1'b1;
      end
    end
    check({tag, ".count"}, 32'(counter_10hz), 32'(model_val));
    check({tag, ".rx_done"}, 32'(rx_total - rx0), ok ? 32'd1 : 32'd0);
    check({tag, ".frame_err"}, 32'(err_total - er0), ok ? 32'd0 : 32'd1);
    checks++;
    assert (lat >= 1 && lat <= LAT_MAX) else begin
      failures++;
      $error("FAIL %s.latency observed=%0d expected=1..%0d", tag, lat, LAT_MAX);
    end
    if (nbits == 16) begin
`ifdef SPI_READBACK_EN
      check({tag, ".readback"}, 32'(rd), 32'(exp_rd));
`else
      check({tag, ".readback"}, 32'(rd), 32'd0);
`endif
    end
  endtask

  initial begin
    logic [31:0] rdata;
    int          rbits;
    bit          rsame;

    repeat (3) @(negedge clk);
    check("reset.count", 32'(counter_10hz), 32'd0);
    check("reset.rx_done", 32'(rx_done), 32'd0);
    check("reset.frame_err", 32'(frame_err), 32'd0);
    check("reset.miso", 32'(miso), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    run_frame("pre_write", 32'h4309, 16, 1'b0);

    // Abort a frame after 7 bits with reset.
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      mosi = 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("midreset.count", 32'(counter_10hz), 32'd0);
    check("midreset.rx_done", 32'(rx_done), 32'd0);
    check("midreset.frame_err", 32'(frame_err), 32'd0);
    check("midreset.miso", 32'(miso), 32'd0);
    model_val = 0;
    @(negedge clk);
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    run_frame("write_1234", 32'h44D2, 16, 1'b0);
    run_frame("write_sat", 32'h7FFF, 16, 1'b0);
    run_frame("set_1234", 32'h44D2, 16, 1'b0);
    run_frame("clear", 32'h8000, 16, 1'b0);
    run_frame("cmd11", 32'hC123, 16, 1'b0);
    run_frame("set_500", 32'h41F4, 16, 1'b0);
    run_frame("short12", 32'h0ABC, 12, 1'b0);
    run_frame("long17", 32'h1_4123, 17, 1'b0);
    run_frame("no_clocks", 32'h0, 0, 1'b0);
    run_frame("write_1", 32'h4001, 16, 1'b0);
    run_frame("same_clk", 32'h4ABC, 16, 1'b1);
    run_frame("rb_set", 32'h44D2, 16, 1'b0);
    run_frame("rb_read", 32'h4777, 16, 1'b0);

    for (int n = 0; n < 24; n++) begin
      rdata = $urandom;
      rbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
      rsame = (rbits > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame($sformatf("rand%0d", n), rdata, rbits, rsame);
    end

    check("never_both", 32'(both_total), 32'd0);
`ifndef SPI_READBACK_EN
    check("miso_idle", 32'(miso_hi_total), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
